// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: register offsets, status layout and FSM encoding.
package uart_rx_pkg;

  localparam logic [31:0] UART_RX_DATA   = 32'h0000_0000;
  localparam logic [31:0] UART_RX_STATUS = 32'h0000_0004;

  localparam int unsigned ST_NOT_EMPTY  = 0;
  localparam int unsigned ST_FULL       = 1;
  localparam int unsigned ST_OVERRUN    = 2;
  localparam int unsigned ST_FRAME_ERR  = 3;
  localparam int unsigned ST_COUNT_LSB  = 8;
  localparam int unsigned RXDATA_VALID  = 31;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  count;
    logic [3:0]  rsvd_lo;
    logic        frame_err;
    logic        overrun;
    logic        full;
    logic        not_empty;
  } status_reg_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with naturally wrapping pointers; head is a combinational read of the oldest entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: 16x oversampling framer, receive FIFO and RXDATA/STATUS registers.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 80000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        serialIn
);

  localparam int unsigned DIV   = CLK_HZ / (BAUD * 16);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  if (DIV == 0) begin : g_bad_div
    $error("uart_rx: CLK_HZ too low for BAUD*16 oversampling");
  end

  logic [DIV_W-1:0] tick_cnt;
  logic             tick_c;
  logic             rx_meta;
  logic             rx_s;

  rx_state_t        state_q, state_d;
  logic [3:0]       scnt_q, scnt_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             push_c;
  logic             frame_set_c;

  logic             overrun_q;
  logic             frame_err_q;

  logic             access_c;
  logic             rd_c;
  logic             wr_c;
  logic             sel_status_c;
  logic             pop_c;
  logic             clr_ovr_c;
  logic             clr_ferr_c;
  logic [31:0]      rdata_c;
  status_reg_t      status_c;

  logic [7:0]       fifo_head_c;
  logic             fifo_full_c;
  logic             fifo_empty_c;
  logic [CW-1:0]    fifo_count;

  logic             unused_c;
  assign unused_c = ^{mem_instr, mem_addr[31:3], mem_addr[1:0], mem_wdata[31:4], mem_wdata[1:0]};

  // Free-running oversample divider and line synchronizer.
  assign tick_c = (tick_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_cnt <= '0;
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      tick_cnt <= tick_c ? '0 : tick_cnt + DIV_W'(1);
      rx_meta  <= serialIn;
      rx_s     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RX_IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Framer: start bit confirmed at mid-bit, data and stop sampled every 16 ticks after that.
  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          scnt_d  = '0;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (tick_c) begin
          if (scnt_q == 4'd7) begin
            if (rx_s) begin
              state_d = RX_IDLE;
            end else begin
              scnt_d  = '0;
              bcnt_d  = '0;
              state_d = RX_DATA;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick_c) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            shreg_d = {rx_s, shreg_q[7:1]};
            if (bcnt_q == 3'd7) state_d = RX_STOP;
            else                bcnt_d  = bcnt_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick_c) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            if (rx_s) begin
              push_c  = 1'b1;
              state_d = RX_IDLE;
            end else begin
              frame_set_c = 1'b1;
              state_d     = RX_BREAK;
            end
          end
        end
      end
      RX_BREAK: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push_c),
    .din     (shreg_q),
    .pop     (pop_c),
    .head_c  (fifo_head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .count   (fifo_count)
  );

  // Bus decode; side effects land on the same edge that raises mem_ready.
  always_comb begin
    access_c     = enable & mem_valid & ~mem_ready;
    rd_c         = access_c & (mem_wstrb == 4'h0);
    wr_c         = access_c & (mem_wstrb != 4'h0);
    sel_status_c = (mem_addr[2] == UART_RX_STATUS[2]);
    pop_c        = rd_c & ~sel_status_c & ~fifo_empty_c;
    clr_ovr_c    = wr_c & sel_status_c & mem_wstrb[0] & mem_wdata[ST_OVERRUN];
    clr_ferr_c   = wr_c & sel_status_c & mem_wstrb[0] & mem_wdata[ST_FRAME_ERR];

    status_c           = '0;
    status_c.not_empty = ~fifo_empty_c;
    status_c.full      = fifo_full_c;
    status_c.overrun   = overrun_q;
    status_c.frame_err = frame_err_q;
    status_c.count     = 8'(fifo_count);

    rdata_c = '0;
    if (rd_c) begin
      if (sel_status_c)       rdata_c = status_c;
      else if (!fifo_empty_c) rdata_c = {1'b1, 23'd0, fifo_head_c};
    end
  end

  // Sticky error bits: a new event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
    end else begin
      overrun_q   <= (push_c & fifo_full_c) | (overrun_q & ~clr_ovr_c);
      frame_err_q <= frame_set_c | (frame_err_q & ~clr_ferr_c);
      mem_ready   <= access_c;
      mem_rdata   <= rdata_c;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=4 (64 clk per bit); bus read results are scoreboarded.
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 64;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        serial_in;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  uart_rx #(
    .CLK_HZ     (7372800),
    .BAUD       (115200),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .serialIn  (serial_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input string tag, input logic [31:0] addr,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
    logic [31:0] exp;
    int lat;
    bit got;
    enable    = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wstrb = wstrb;
    mem_wdata = wdata;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      wait_clks(1);
      lat++;
      if (mem_ready === 1'b1) got = 1'b1;
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_ready"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_rdata"}, mem_rdata, exp);
    enable    = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    mem_wdata = '0;
    wait_clks(1);
    chk({tag, "_ready_drop"}, {31'd0, mem_ready}, 32'd0);
    chk({tag, "_rdata_idle"}, mem_rdata, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus_xfer(tag, addr, 4'h0, 32'd0);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back(32'd0);
    bus_xfer(tag, addr, 4'h1, data);
  endtask

  // stop_low > 0 holds the stop bit low for that many clocks before releasing the line.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    serial_in = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      wait_clks(BIT_CLKS);
    end
    if (stop_low > 0) begin
      serial_in = 1'b0;
      wait_clks(stop_low);
    end
    serial_in = 1'b1;
    wait_clks(BIT_CLKS);
  endtask

  initial begin
    resetn    = 1'b0;
    enable    = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    serial_in = 1'b1;
    wait_clks(3);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    resetn = 1'b1;
    wait_clks(2);
    rd("rst_status", 32'h4, 32'h0);
    rd("rst_rxdata_empty", 32'h0, 32'h0);

    // Single character
    send_frame(8'h55, 0);
    rd("rx55_data", 32'h0, 32'h8000_0055);
    rd("rx55_status", 32'h4, 32'h0);

    // Back-to-back "Hi"
    send_frame(8'h48, 0);
    send_frame(8'h69, 0);
    rd("hi_status", 32'h4, 32'h0000_0201);
    rd("hi_data0", 32'h0, 32'h8000_0048);
    rd("hi_data1", 32'h0, 32'h8000_0069);
    rd("hi_data_empty", 32'h0, 32'h0);

    // Short low glitch is rejected, next real frame is received
    serial_in = 1'b0;
    wait_clks(20);
    serial_in = 1'b1;
    wait_clks(100);
    rd("glitch_status", 32'h4, 32'h0);
    send_frame(8'hA3, 0);
    rd("a3_data", 32'h0, 32'h8000_00A3);

    // Framing error followed by a long break
    send_frame(8'h3C, 200);
    rd("break_status", 32'h4, 32'h0000_0008);
    wr("break_w1c", 32'h4, 32'h0000_0008);
    rd("break_status_clr", 32'h4, 32'h0);
    rd("break_no_data", 32'h0, 32'h0);

    // Overfill the FIFO by one byte
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 0);
    rd("fill_status", 32'h4, 32'h0000_1007);
    wr("fill_data_write_ignored", 32'h0, 32'hFFFF_FFFF);
    for (int i = 0; i < 16; i++) rd("fill_data", 32'h0, 32'h8000_0000 | 32'(i));
    rd("fill_lost", 32'h0, 32'h0);
    rd("fill_status_ovr", 32'h4, 32'h0000_0004);
    wr("fill_w1c", 32'h4, 32'h0000_0004);
    rd("fill_status_clr", 32'h4, 32'h0);

    // Reset in the middle of data bit 4 of 0xF0 abandons the frame
    serial_in = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      serial_in = 1'b0;
      wait_clks(BIT_CLKS);
    end
    serial_in = 1'b1;
    wait_clks(BIT_CLKS / 2);
    resetn = 1'b0;
    wait_clks(1);
    resetn = 1'b1;
    chk("midrst_ready", {31'd0, mem_ready}, 32'd0);
    wait_clks(BIT_CLKS * 5);
    rd("midrst_status", 32'h4, 32'h0);
    send_frame(8'hFF, 0);
    rd("ff_data", 32'h0, 32'h8000_00FF);
    rd("ff_status", 32'h4, 32'h0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
